// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB round-robin arbiter slice.
//   apb_state_e    : APB master sequencing states (IDLE -> SETUP -> ACCESS)
//   APB_ADDR_WIDTH : default APB address width
//   APB_DATA_WIDTH : default APB data width
//   APB_TIMEOUT    : default number of ACCESS cycles allowed before abort
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_TIMEOUT    = 16;

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: rotate the request vector so the pointer
// position lands on bit 0, take the lowest set bit, then rotate the one-hot
// result back into client order.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    highest-priority client index
//   grant out NUM_REQ  one-hot grant (all zero when no request)
//   idx   out PTR_W    index of the granted client
//   any   out 1        at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] gnt_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   gnt_rot;
    logic [PTR_W-1:0]     rot_idx;
    logic [PTR_W:0]       idx_sum;

    // Doubling the vector turns a rotate into a plain shift; the descending
    // loop lets the lowest rotated position (closest to the pointer) win.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[NUM_REQ-1:0];
        gnt_rot = '0;
        rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_rot    = '0;
                gnt_rot[i] = 1'b1;
                rot_idx    = PTR_W'(i);
            end
        end
        gnt_dbl = {gnt_rot, gnt_rot} << ptr;
        grant   = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
        idx_sum = {1'b0, ptr} + {1'b0, rot_idx};
        if (idx_sum >= (PTR_W+1)'(NUM_REQ)) begin
            idx = PTR_W'(idx_sum - (PTR_W+1)'(NUM_REQ));
        end else begin
            idx = idx_sum[PTR_W-1:0];
        end
        any = |req;
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// APB master shared round-robin between NUM_REQ clients. A winning request is
// captured, sequenced through SETUP/ACCESS, and the response is routed back
// to the client that won. Stalled ACCESS phases are aborted with an error.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_write      per-client request and direction
//   req_addr/wdata/strobe    packed per-client transfer fields
//   req_ready                one-hot pulse when a request is captured
//   rsp_valid                one-hot pulse when the transfer finishes
//   rsp_rdata/rsp_slverr     response data and error, valid with rsp_valid
//   psel/penable/pwrite      APB controls
//   ptrnsfr                  another transfer is pending during ACCESS
//   paddr/pwdata/pstrb       APB transfer fields
//   pready/pslverr/prdata    APB slave response
// ---------------------------------------------------------------------------
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = APB_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strobe,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_slverr,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic                          ptrnsfr,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    output logic [STRB_WIDTH-1:0]         pstrb,
    input  logic                          pready,
    input  logic                          pslverr,
    input  logic [DATA_WIDTH-1:0]         prdata
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e         state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   to_cnt;
    logic [NUM_REQ-1:0] cap_grant;
    logic [NUM_REQ-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic               do_capture;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A new request is taken from IDLE, or back-to-back when the current
    // transfer completes normally (a timeout always falls back to IDLE).
    assign do_capture = pick_any &&
                        ((state == IDLE) || ((state == ACCESS) && pready));

    assign ptrnsfr = (state == ACCESS) && (|req_valid);

    // Capture registers double as the APB field outputs, so they only change
    // on the edge into SETUP and stay stable through the whole transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            cap_grant <= '0;
            req_ready <= '0;
            ptr       <= '0;
        end else begin
            req_ready <= '0;
            if (do_capture) begin
                pwrite    <= req_write[pick_idx];
                paddr     <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                pwdata    <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                pstrb     <= req_strobe[pick_idx*STRB_WIDTH +: STRB_WIDTH];
                cap_grant <= pick_grant;
                req_ready <= pick_grant;
                ptr       <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                               : PTR_W'(pick_idx + 1'b1);
            end
        end
    end

    // APB sequencing, timeout counting and the registered response pulse.
    // pready is tested before the timeout so a completion on the last
    // allowed cycle is still reported as a normal transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            to_cnt     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                    to_cnt  <= '0;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid  <= cap_grant;
                        rsp_rdata  <= pwrite ? '0 : prdata;
                        rsp_slverr <= pslverr;
                        penable    <= 1'b0;
                        if (pick_any) begin
                            state <= SETUP;
                        end else begin
                            state <= IDLE;
                            psel  <= 1'b0;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        rsp_valid  <= cap_grant;
                        rsp_slverr <= 1'b1;
                        state      <= IDLE;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_arbiter
// Directed bench for apb_rr_arbiter: a table of single transfers with hand
// computed grants and responses, plus sequences for back-to-back transfers,
// timeout, pready on the final allowed cycle and reset during ACCESS.
// ---------------------------------------------------------------------------
module tb_apb_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ*SW-1:0] req_strobe;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_slverr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic                  ptrnsfr;
    logic [AW-1:0]         paddr;
    logic [DW-1:0]         pwdata;
    logic [SW-1:0]         pstrb;
    logic                  pready;
    logic                  pslverr;
    logic [DW-1:0]         prdata;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [3:0]  mask;
        logic        write;
        logic [31:0] base;
        logic [31:0] wdata;
        logic [3:0]  strobe;
        int          wait_cycles;
        logic        slverr;
        logic [31:0] prdata;
        logic [3:0]  exp_grant;
        int          exp_idx;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [0:8];

    always #5 clk = ~clk;

    apb_rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strobe (req_strobe),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .ptrnsfr    (ptrnsfr),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata)
    );

    // Every output is sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Client c presents address base + 16*c so paddr identifies the winner.
    task automatic applyStimulus(input vec_t v);
        for (int c = 0; c < NUM_REQ; c++) begin
            req_addr[c*AW +: AW]   = v.base + 32'(c * 16);
            req_wdata[c*DW +: DW]  = v.wdata;
            req_strobe[c*SW +: SW] = v.strobe;
            req_write[c]           = v.write;
        end
        req_valid = v.mask;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        req_valid = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic runVector(input vec_t v);
        logic [AW-1:0] exp_addr;
        exp_addr = v.base + 32'(v.exp_idx * 16);
        applyStimulus(v);
        tick();
        checkOutput("req_ready", 128'(req_ready), 128'(v.exp_grant));
        checkOutput("setup_psel_penable", 128'({psel, penable}), 128'(2'b10));
        checkOutput("setup_paddr", 128'(paddr), 128'(exp_addr));
        checkOutput("setup_pwrite", 128'(pwrite), 128'(v.write));
        checkOutput("setup_pwdata_pstrb", 128'({pwdata, pstrb}), 128'({v.wdata, v.strobe}));
        req_valid = '0;
        tick();
        checkOutput("access_ctl", 128'({psel, penable, ptrnsfr}), 128'(3'b110));
        checkOutput("access_stable", 128'({paddr, pwrite, pwdata, pstrb}),
                    128'({exp_addr, v.write, v.wdata, v.strobe}));
        pready = 1'b0;
        for (int k = 0; k < v.wait_cycles; k++) tick();
        pready  = 1'b1;
        prdata  = v.prdata;
        pslverr = v.slverr;
        tick();
        checkOutput("rsp_valid", 128'(rsp_valid), 128'(v.exp_grant));
        checkOutput("rsp_rdata", 128'(rsp_rdata), 128'(v.exp_rdata));
        checkOutput("rsp_slverr", 128'(rsp_slverr), 128'(v.exp_err));
        checkOutput("back_to_idle", 128'({psel, penable}), 128'(2'b00));
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] exp_seq [0:4];
        vec_t       tv;

        // mask, write, base, wdata, strobe, wait, slverr, prdata, grant, idx, rdata, err
        vecs[0] = '{4'b0010, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 1, 1'b0, 32'hDEAD_BEEF, 4'b0010, 1, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{4'b0100, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b0011, 0, 1'b0, 32'h1234_5678, 4'b0100, 2, 32'h0, 1'b0};
        vecs[2] = '{4'b1111, 1'b0, 32'h0000_2000, 32'h0000_0000, 4'hF, 0, 1'b0, 32'h3333_0003, 4'b1000, 3, 32'h3333_0003, 1'b0};
        vecs[3] = '{4'b1111, 1'b0, 32'h0000_3000, 32'h0000_0000, 4'hF, 2, 1'b0, 32'h0000_0A0A, 4'b0001, 0, 32'h0000_0A0A, 1'b0};
        vecs[4] = '{4'b0101, 1'b1, 32'h0000_4000, 32'h0BAD_F00D, 4'b1100, 0, 1'b0, 32'hFFFF_FFFF, 4'b0100, 2, 32'h0, 1'b0};
        vecs[5] = '{4'b0001, 1'b0, 32'h0000_5000, 32'h0000_0000, 4'hF, 0, 1'b1, 32'h5555_AAAA, 4'b0001, 0, 32'h5555_AAAA, 1'b1};
        vecs[6] = '{4'b1001, 1'b0, 32'h0000_6000, 32'h0000_0000, 4'hF, 1, 1'b0, 32'h6666_0006, 4'b1000, 3, 32'h6666_0006, 1'b0};
        vecs[7] = '{4'b0110, 1'b1, 32'h0000_7000, 32'h7777_7777, 4'b0001, 2, 1'b1, 32'h1111_1111, 4'b0010, 1, 32'h0, 1'b1};
        vecs[8] = '{4'b0011, 1'b0, 32'h0000_8000, 32'h0000_0000, 4'hF, 0, 1'b0, 32'h8888_0008, 4'b0001, 0, 32'h8888_0008, 1'b0};

        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_strobe = '0;
        doReset();
        checkOutput("reset_outputs",
                    128'({req_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable,
                          pwrite, ptrnsfr, paddr, pwdata, pstrb}), 128'(0));

        for (int i = 0; i < 9; i++) begin
            runVector(vecs[i]);
            tick();
        end

        // All clients keep requesting with an always-ready slave.
        doReset();
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0001;
        tv = vecs[2];
        applyStimulus(tv);
        pready = 1'b1;
        prdata = 32'h0000_00C0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("b2b_req_ready", 128'(req_ready), 128'(exp_seq[i]));
            checkOutput("b2b_setup_penable", 128'({psel, penable}), 128'(2'b10));
            if (i > 0) begin
                checkOutput("b2b_rsp_valid", 128'(rsp_valid), 128'(exp_seq[i-1]));
            end
            tick();
            checkOutput("b2b_access_ptrnsfr", 128'({psel, penable, ptrnsfr}), 128'(3'b111));
            tick();
        end

        // No pready: abort after 16 ACCESS cycles with an error.
        doReset();
        tv = vecs[5];
        applyStimulus(tv);
        tick();
        req_valid = '0;
        prdata    = 32'hFFFF_0000;
        tick();
        repeat (15) tick();
        checkOutput("timeout_still_access", 128'({rsp_valid, psel, penable}), 128'(6'b0000_11));
        tick();
        checkOutput("timeout_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
        checkOutput("timeout_rsp_err_data", 128'({rsp_slverr, rsp_rdata}), 128'({1'b1, 32'h0}));
        checkOutput("timeout_idle", 128'({psel, penable}), 128'(2'b00));

        // pready on the 16th ACCESS cycle beats the timeout.
        doReset();
        applyStimulus(tv);
        tick();
        req_valid = '0;
        tick();
        repeat (15) tick();
        pready = 1'b1;
        prdata = 32'hCAFE_F00D;
        tick();
        checkOutput("late_pready_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
        checkOutput("late_pready_rsp", 128'({rsp_slverr, rsp_rdata}), 128'({1'b0, 32'hCAFE_F00D}));
        pready = 1'b0;

        // Reset during ACCESS aborts the transfer and resets the pointer.
        doReset();
        tv = vecs[0];
        applyStimulus(tv);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_access_outputs",
                    128'({req_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable,
                          pwrite, ptrnsfr, paddr, pwdata, pstrb}), 128'(0));
        rst = 1'b0;
        tick();
        checkOutput("rst_no_rsp", 128'({rsp_valid, psel}), 128'(5'b0000_0));
        tv.mask = 4'b1001;
        applyStimulus(tv);
        tick();
        checkOutput("rst_pointer_zero", 128'(req_ready), 128'(4'b0001));
        req_valid = '0;
        tv.mask = 4'b1000;
        tick();
        tick();
        pready = 1'b1;
        tick();
        pready = 1'b0;
        applyStimulus(tv);
        tick();
        checkOutput("rst_client3_grant", 128'(req_ready), 128'(4'b1000));
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
